// File: rtl/pa_isa_pkg.sv
// pa_isa_pkg: PA instruction word layout shared by fetch and decode.
// Bit positions and widths of each field in the 32-bit instruction word,
// and the packed field bundle handed from fetch to decode.
package pa_isa_pkg;

  localparam int WORD_W       = 32;
  localparam int ISBRANCH_BIT = 29;
  localparam int FORMAT_BIT   = 28;
  localparam int OPCODE_MSB   = 27;
  localparam int OPCODE_LSB   = 21;
  localparam int PRIM_MSB     = 20;
  localparam int PRIM_LSB     = 16;
  localparam int SEC_MSB      = 15;
  localparam int SEC_LSB      = 0;

  localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int PRIM_W   = PRIM_MSB - PRIM_LSB + 1;
  localparam int SEC_W    = SEC_MSB - SEC_LSB + 1;

  typedef struct packed {
    logic                is_branch;
    logic                fmt;        // 1 = register-immediate
    logic [OPCODE_W-1:0] opcode;
    logic [PRIM_W-1:0]   prim;
    logic [SEC_W-1:0]    sec;
  } fields_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction-memory request/acknowledge bus.
//   memReq  : request valid (fetch -> memory)
//   memAddr : word address, stable until memAck (fetch -> memory)
//   memAck  : request completes this cycle (memory -> fetch)
//   memData : instruction word, valid with memReq && memAck (memory -> fetch)
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 16
);
  import pa_isa_pkg::*;

  logic                  memReq;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memAck;
  logic [WORD_W-1:0]     memData;

  modport master (output memReq, memAddr, input  memAck, memData);
  modport slave  (input  memReq, memAddr, output memAck, memData);
endinterface

// File: rtl/instruction_field_split.sv
// instruction_field_split: purely combinational split of a 32-bit
// instruction word into decode fields. Bits 31:30 are reserved.
//   i_word   : instruction word
//   o_fields : isBranch / format / opcode / primary / secondary fields
module instruction_field_split
  import pa_isa_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output fields_t           o_fields
);

  logic w_unused_rsvd;
  assign w_unused_rsvd = ^i_word[WORD_W-1:ISBRANCH_BIT+1];

  assign o_fields.is_branch = i_word[ISBRANCH_BIT];
  assign o_fields.fmt       = i_word[FORMAT_BIT];
  assign o_fields.opcode    = i_word[OPCODE_MSB:OPCODE_LSB];
  assign o_fields.prim      = i_word[PRIM_MSB:PRIM_LSB];
  assign o_fields.sec       = i_word[SEC_MSB:SEC_LSB];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PA front-end fetch stage.
// Holds the PC, fetches words over mem_if, and presents decoded fields to
// decode with a one-cycle enable pulse. Supports downstream stall (word is
// parked in a one-entry buffer) and branch redirect.
//   clock_i / reset_n_i        : clock, async active-low reset
//   stall_i                    : decode cannot accept this cycle
//   redirect_i/redirectAddr_i  : restart fetch at redirectAddr_i
//   mem_if (master)            : instruction memory request/ack bus
//   enable_o                   : fields and pc_o valid this cycle
//   isBranch_o .. secOperand_o : instruction fields, held when enable_o=0
//   pc_o                       : address of the presented instruction
module instruction_fetch
  import pa_isa_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirectAddr_i,
  instruction_fetch_if.master   mem_if,
  output logic                  enable_o,
  output logic                  isBranch_o,
  output logic                  instructionFormat_o,
  output logic [OPCODE_W-1:0]   opcode_o,
  output logic [PRIM_W-1:0]     primOperand_o,
  output logic [SEC_W-1:0]      secOperand_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  typedef enum logic [1:0] {S_START, S_FETCH, S_HOLD, S_DRAIN} state_e;

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [ADDR_WIDTH-1:0] r_target;
  logic [ADDR_WIDTH-1:0] r_buf_pc;
  logic [WORD_W-1:0]     r_buf_word;
  logic [ADDR_WIDTH-1:0] r_pc_out;
  fields_t               r_fields;
  logic                  r_enable;

  fields_t w_direct, w_held;
  logic    w_present, w_use_buf, w_buf_load, w_tgt_load;

  // The PC only moves on a completed handshake or a HOLD redirect, so in
  // DRAIN it still equals the address of the outstanding request.
  assign mem_if.memReq  = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign mem_if.memAddr = r_pc;

  instruction_field_split u_split_direct (.i_word(mem_if.memData), .o_fields(w_direct));
  instruction_field_split u_split_held   (.i_word(r_buf_word),     .o_fields(w_held));

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_present   = 1'b0;
    w_use_buf   = 1'b0;
    w_buf_load  = 1'b0;
    w_tgt_load  = 1'b0;
    unique case (r_state)
      S_START: w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_if.memAck) begin
          if (redirect_i) begin
            w_pc_nxt = redirectAddr_i;       // word is wrong-path, drop it
          end else begin
            w_pc_nxt = r_pc + 1'b1;
            if (stall_i) begin
              w_buf_load  = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_present = 1'b1;
            end
          end
        end else if (redirect_i) begin
          // Request must stay up until acked; remember where to go after.
          w_tgt_load  = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          w_pc_nxt    = redirectAddr_i;
          w_state_nxt = S_FETCH;
        end else if (!stall_i) begin
          w_present   = 1'b1;
          w_use_buf   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        w_tgt_load = redirect_i;
        if (mem_if.memAck) begin
          w_pc_nxt    = redirect_i ? redirectAddr_i : r_target;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_START;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_START;
      r_pc       <= RESET_PC;
      r_target   <= '0;
      r_buf_pc   <= '0;
      r_buf_word <= '0;
      r_pc_out   <= '0;
      r_fields   <= '0;
      r_enable   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_enable <= w_present;
      if (w_tgt_load) r_target <= redirectAddr_i;
      if (w_buf_load) begin
        r_buf_word <= mem_if.memData;
        r_buf_pc   <= r_pc;
      end
      if (w_present) begin
        r_fields <= w_use_buf ? w_held   : w_direct;
        r_pc_out <= w_use_buf ? r_buf_pc : r_pc;
      end
    end
  end

  assign enable_o            = r_enable;
  assign isBranch_o          = r_fields.is_branch;
  assign instructionFormat_o = r_fields.fmt;
  assign opcode_o            = r_fields.opcode;
  assign primOperand_o       = r_fields.prim;
  assign secOperand_o        = r_fields.sec;
  assign pc_o                = r_pc_out;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized bench for instruction_fetch against a
// transaction-level model: a queue of fetched-but-not-presented words, the
// next address the stage should fetch, and a flag for a request whose word
// was killed by a redirect. A second 4-bit-address instance covers PC wrap.
module tb_instruction_fetch;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  // ---------------- main DUT (ADDR_WIDTH 16) ----------------
  logic        rst_n, stall, redirect;
  logic [15:0] raddr;
  logic        en, isb, fmt;
  logic [6:0]  opc;
  logic [4:0]  prim;
  logic [15:0] sec, pc_out;
  logic [29:0] obsf;
  assign obsf = {isb, fmt, opc, prim, sec};

  instruction_fetch_if #(.ADDR_WIDTH(16)) mem ();

  instruction_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock_i(gclk), .reset_n_i(rst_n), .stall_i(stall), .redirect_i(redirect),
    .redirectAddr_i(raddr), .mem_if(mem.master), .enable_o(en),
    .isBranch_o(isb), .instructionFormat_o(fmt), .opcode_o(opc),
    .primOperand_o(prim), .secOperand_o(sec), .pc_o(pc_out));

  // ---------------- wrap DUT (ADDR_WIDTH 4, zero-wait memory) ----------------
  logic        rst2_n, redirect2;
  logic [3:0]  raddr2, pc2;
  logic        en2, isb2, fmt2;
  logic [6:0]  opc2;
  logic [4:0]  prim2;
  logic [15:0] sec2;

  instruction_fetch_if #(.ADDR_WIDTH(4)) mem2 ();
  assign mem2.memAck  = 1'b1;
  assign mem2.memData = 32'h2000_0000 | {28'h0, mem2.memAddr};

  instruction_fetch #(.ADDR_WIDTH(4), .RESET_PC(4'h0)) dut2 (
    .clock_i(gclk), .reset_n_i(rst2_n), .stall_i(1'b0), .redirect_i(redirect2),
    .redirectAddr_i(raddr2), .mem_if(mem2.master), .enable_o(en2),
    .isBranch_o(isb2), .instructionFormat_o(fmt2), .opcode_o(opc2),
    .primOperand_o(prim2), .secOperand_o(sec2), .pc_o(pc2));

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] pc;
    logic [31:0] w;
  } item_t;

  item_t       q[$];
  item_t       exp_item, last_item;
  bit          exp_en;
  logic [15:0] m_next;
  bit          m_discard;
  bit          prev_req, prev_ack;
  logic [15:0] prev_addr;
  int          mem_mode;
  int          n_pres;

  function automatic logic [31:0] mem_word(input int mode, input logic [15:0] a);
    case (mode)
      0:       return 32'h2000_0000 | {16'h0, a};
      1:       return 32'h1FE3_ABCD;
      default: return ({a, a} * 32'h9E37_79B9) ^ 32'h3C5A_A5C3;
    endcase
  endfunction

  function automatic logic [29:0] fld(input logic [31:0] w);
    return {w[29], w[28], w[27:21], w[20:16], w[15:0]};
  endfunction

  // Wait for the next edge, then check what that edge produced.
  task automatic tick();
    @(posedge gclk);
    #1;
    chk("enable", 64'(en), 64'(exp_en));
    if (exp_en) begin
      chk("pc_o", 64'(pc_out), 64'(exp_item.pc));
      chk("fields", 64'(obsf), 64'(fld(exp_item.w)));
      last_item = exp_item;
      n_pres++;
    end else begin
      chk("hold_pc", 64'(pc_out), 64'(last_item.pc));
      chk("hold_fields", 64'(obsf), 64'(fld(last_item.w)));
    end
    // Requesting exactly when no fetched word is waiting for decode.
    chk("req_state", 64'(mem.memReq), 64'(q.size() == 0));
    if (prev_req && !prev_ack) begin
      chk("req_held", 64'(mem.memReq), 64'd1);
      chk("addr_held", 64'(mem.memAddr), 64'(prev_addr));
    end
  endtask

  // Apply inputs for this cycle and advance the model across the next edge.
  task automatic drive(input bit st, input bit rd, input logic [15:0] ra, input bit ack);
    bit hs;
    stall      = st;
    redirect   = rd;
    raddr      = ra;
    mem.memAck = ack;
    mem.memData = (ack && mem.memReq) ? mem_word(mem_mode, mem.memAddr) : $urandom;
    hs = mem.memReq && mem.memAck;
    if (mem.memReq && !m_discard) chk("req_addr", 64'(mem.memAddr), 64'(m_next));
    exp_en = 1'b0;
    if (redirect) begin
      q.delete();
      m_discard = mem.memReq && !mem.memAck;
      m_next    = raddr;
    end else if (hs) begin
      if (m_discard) m_discard = 1'b0;
      else begin
        q.push_back('{m_next, mem_word(mem_mode, m_next)});
        m_next = m_next + 16'd1;
      end
    end
    if (q.size() > 0 && !stall && !redirect) begin
      exp_item = q.pop_front();
      exp_en   = 1'b1;
    end
    prev_req  = mem.memReq;
    prev_addr = mem.memAddr;
    prev_ack  = mem.memAck;
  endtask

  task automatic do_reset();
    @(posedge gclk);
    #1;
    rst_n      = 1'b0;
    mem.memAck = 1'b1;   // acks during reset must be ignored
    #1;
    chk("rst_enable", 64'(en), 64'd0);
    chk("rst_req", 64'(mem.memReq), 64'd0);
    chk("rst_pc_o", 64'(pc_out), 64'd0);
    chk("rst_fields", 64'(obsf), 64'd0);
    q.delete();
    m_next    = 16'h0000;
    m_discard = 1'b0;
    exp_en    = 1'b0;
    last_item = '{16'h0, 32'h0};
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    repeat (2) @(posedge gclk);
    #2;
    stall      = 1'b0;
    redirect   = 1'b0;
    mem.memAck = 1'b0;
    rst_n      = 1'b1;
    #1;
    chk("start_noreq", 64'(mem.memReq), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, stall_left, w, n2, pres0;
    bit done, fired, sent;
    logic [3:0] got[4];
    rst_n = 1'b0; rst2_n = 1'b0; stall = 1'b0; redirect = 1'b0; raddr = '0;
    redirect2 = 1'b0; raddr2 = '0;
    mem.memAck = 1'b0; mem.memData = '0;
    mem_mode = 0; n_pres = 0; last_item = '{16'h0, 32'h0};

    // Zero-wait memory, no stall: enable every cycle from cycle 3.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (en) cnt++;
      drive(1'b0, 1'b0, 16'h0, 1'b1);
    end
    chk("stream_count", 64'(cnt), 64'd19);

    // Field split of a fixed word.
    mem_mode = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(1'b0, 1'b0, 16'h0, 1'b1);
    end
    chk("word_fields", 64'(obsf), 64'({1'b0, 1'b1, 7'h7F, 5'h03, 16'hABCD}));
    mem_mode = 0;

    // Three-cycle stall starting at the ack of pc=5.
    do_reset();
    stall_left = 0; done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!done && mem.memReq && mem.memAddr == 16'd5) begin
        stall_left = 3;
        done = 1'b1;
      end
      drive(stall_left > 0, 1'b0, 16'h0, 1'b1);
      if (stall_left > 0) stall_left--;
    end

    // Ack delayed 4 cycles, redirect to 0x0100 on the second waiting cycle.
    do_reset();
    w = 0; fired = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (!fired) begin
        fired = (w == 4);
        drive(1'b0, w == 1, 16'h0100, w == 4);
        w++;
        if (fired) begin
          tick();
          chk("redir_addr", 64'(mem.memAddr), 64'h0100);
          drive(1'b0, 1'b0, 16'h0, 1'b1);
        end
      end else begin
        drive(1'b0, 1'b0, 16'h0, 1'b1);
      end
    end

    // Reset in the middle of an unacked request, then refetch from RESET_PC.
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b0, 1'b0, 16'h0, 1'b0);
    end
    do_reset();
    tick();
    chk("refetch_addr", 64'(mem.memAddr), 64'h0000);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b0, 1'b0, 16'h0, 1'b1);
    end

    // Randomized traffic: variable latency, stalls, redirects, resets.
    mem_mode = 2;
    pres0 = n_pres;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ra;
      if ($urandom_range(0, 299) == 0) do_reset();
      tick();
      ra = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                       : 16'($urandom);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, ra,
            $urandom_range(0, 9) < 6);
    end
    chk("rand_progress", 64'(n_pres - pres0 > 300), 64'd1);

    // 4-bit PC: redirect to E, presented sequence must wrap E,F,0,1.
    @(posedge gclk);
    #2;
    rst2_n = 1'b1;
    sent = 1'b0; n2 = 0;
    for (int i = 0; i < 20 && n2 < 4; i++) begin
      @(posedge gclk);
      #1;
      if (en2) begin
        got[n2] = pc2;
        n2++;
      end
      if (!sent && mem2.memReq) begin
        redirect2 = 1'b1;
        raddr2    = 4'hE;
        sent      = 1'b1;
      end else begin
        redirect2 = 1'b0;
      end
    end
    chk("wrap_count", 64'(n2), 64'd4);
    if (n2 == 4) begin
      chk("wrap_pc0", 64'(got[0]), 64'hE);
      chk("wrap_pc1", 64'(got[1]), 64'hF);
      chk("wrap_pc2", 64'(got[2]), 64'h0);
      chk("wrap_pc3", 64'(got[3]), 64'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
